// File: rtl/cdc_handshake_tx.sv
// Source-domain half of a two-phase (toggle) req/ack crossing: latches one word,
// toggles o_xfer_req, and waits for the synchronized ack toggle to match.
module cdc_handshake_tx #(
  parameter int C_WIDTH       = 32,
  parameter int C_SYNC_LEVELS = 2,
  parameter int C_TIMEOUT     = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [C_WIDTH-1:0] i_data,
  output logic               o_xfer_req,
  output logic [C_WIDTH-1:0] o_xfer_data,
  input  logic               i_xfer_ack,
  output logic               o_done,
  output logic               o_busy,
  output logic               o_timeout,
  input  logic               i_clr_timeout
);

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic                     xfer_req_q, xfer_req_d;
  logic [C_WIDTH-1:0]       xfer_data_q, xfer_data_d;
  logic [C_SYNC_LEVELS-1:0] ack_sync_q, ack_sync_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     ack_sync;
  logic                     accept;

  assign o_ready  = (state_q == IDLE) && !i_rst;
  assign accept   = i_valid && o_ready;
  assign ack_sync = ack_sync_q[C_SYNC_LEVELS-1];

  always_comb begin
    state_d     = state_q;
    xfer_req_d  = xfer_req_q;
    xfer_data_d = xfer_data_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    // The chain keeps tracking ack even in IDLE, so a stray toggle is absorbed
    // and simply becomes the reference for the next request.
    ack_sync_d  = {ack_sync_q[C_SYNC_LEVELS-2:0], i_xfer_ack};
    case (state_q)
      IDLE: begin
        if (accept) begin
          xfer_data_d = i_data;
          xfer_req_d  = ~xfer_req_q;
          state_d     = WAIT_ACK;
          busy_d      = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack_sync == xfer_req_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      xfer_req_q  <= 1'b0;
      xfer_data_q <= '0;
      ack_sync_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      xfer_req_q  <= xfer_req_d;
      xfer_data_q <= xfer_data_d;
      ack_sync_q  <= ack_sync_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign o_xfer_req  = xfer_req_q;
  assign o_xfer_data = xfer_data_q;
  assign o_done      = done_q;
  assign o_busy      = busy_q;

  generate
    if (C_TIMEOUT > 0) begin : g_timeout
      localparam int CW = $clog2(C_TIMEOUT + 1);
      logic [CW-1:0] cnt_q, cnt_d;
      logic          timeout_q, timeout_d;
      logic          timeout_set;

      // Set is an event on the edge the count reaches the limit, so a later
      // clear sticks even while the transfer is still outstanding.
      always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
          cnt_d = '0;
        end else if (state_q == WAIT_ACK && cnt_q != CW'(C_TIMEOUT)) begin
          cnt_d = cnt_q + 1'b1;
        end
        timeout_set = (state_q == WAIT_ACK) && (cnt_q == CW'(C_TIMEOUT - 1));
        timeout_d   = timeout_q;
        if (timeout_set) begin
          timeout_d = 1'b1;
        end else if (i_clr_timeout) begin
          timeout_d = 1'b0;
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          cnt_q     <= '0;
          timeout_q <= 1'b0;
        end else begin
          cnt_q     <= cnt_d;
          timeout_q <= timeout_d;
        end
      end

      assign o_timeout = timeout_q;
    end else begin : g_no_timeout
      logic unused_clr_timeout;
      assign unused_clr_timeout = i_clr_timeout;
      assign o_timeout          = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: a vector table for the single-transfer,
// spurious-ack and reset cases, then sequences for back-to-back, stall, timeout.
module tb_cdc_handshake_tx;

  logic        clk = 1'b0;
  logic        rst, valid, ready, req, ack, done, busy, tmo, clr;
  logic [31:0] data, xdata;

  logic        rx_auto = 1'b0;
  logic        ack_manual = 1'b0;
  logic        ack_model, rx_seen;
  int          rx_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign ack = rx_auto ? ack_model : ack_manual;

  cdc_handshake_tx #(
    .C_WIDTH(32),
    .C_SYNC_LEVELS(2),
    .C_TIMEOUT(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_valid(valid),
    .o_ready(ready),
    .i_data(data),
    .o_xfer_req(req),
    .o_xfer_data(xdata),
    .i_xfer_ack(ack),
    .o_done(done),
    .o_busy(busy),
    .o_timeout(tmo),
    .i_clr_timeout(clr)
  );

  // Receiver model: returns the req level on ack three cycles after seeing a toggle.
  always @(posedge clk) begin
    if (!rx_auto) begin
      rx_seen   <= req;
      rx_cnt    <= 0;
      ack_model <= ack_manual;
    end else if (rx_cnt != 0) begin
      rx_cnt <= rx_cnt - 1;
      if (rx_cnt == 1) ack_model <= rx_seen;
    end else if (req != rx_seen) begin
      rx_seen <= req;
      rx_cnt  <= 3;
    end
  end

  typedef struct {
    logic        rst, valid, ack, clr;
    logic [31:0] data;
    logic        e_ready, e_req, e_done, e_busy, e_to;
    logic [31:0] e_xdata;
  } vec_t;

  vec_t vecs[21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic a, input logic [31:0] d,
                              input logic erd, input logic erq, input logic edn,
                              input logic ebs, input logic eto, input logic [31:0] exd);
    vec_t t;
    t.rst = r; t.valid = v; t.ack = a; t.clr = 1'b0; t.data = d;
    t.e_ready = erd; t.e_req = erq; t.e_done = edn; t.e_busy = ebs; t.e_to = eto;
    t.e_xdata = exd;
    return t;
  endfunction

  initial begin
    logic        acc, prev_req;
    logic [31:0] cur;
    logic [31:0] words[3];
    logic        exp_reqs[3];
    int          idx, ndone, cyc;

    rst = 1'b1; valid = 1'b0; data = '0; clr = 1'b0;

    //           rst  vld  ack  data          rdy  req  done busy to   xdata
    vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[1]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[2]  = mk(1'b0,1'b1,1'b0,32'hDEADBEEF, 1'b0,1'b1,1'b0,1'b1,1'b0,32'hDEADBEEF);
    vecs[3]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,32'hDEADBEEF);
    vecs[4]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,32'hDEADBEEF);
    vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,32'hDEADBEEF);
    vecs[6]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,32'hDEADBEEF);
    vecs[7]  = mk(1'b0,1'b0,1'b1,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,32'hDEADBEEF);
    vecs[8]  = mk(1'b0,1'b0,1'b1,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,32'hDEADBEEF);
    vecs[9]  = mk(1'b0,1'b0,1'b1,32'h0,        1'b1,1'b1,1'b1,1'b0,1'b0,32'hDEADBEEF);
    vecs[10] = mk(1'b0,1'b0,1'b1,32'h0,        1'b1,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF);
    // spurious ack toggle while idle
    vecs[11] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF);
    vecs[12] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF);
    vecs[13] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF);
    vecs[14] = mk(1'b0,1'b1,1'b0,32'h5A5A5A5A, 1'b0,1'b0,1'b0,1'b1,1'b0,32'h5A5A5A5A);
    vecs[15] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0,32'h5A5A5A5A);
    vecs[16] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,32'h5A5A5A5A);
    // reset in WAIT_ACK with req=1
    vecs[17] = mk(1'b0,1'b1,1'b0,32'h00001234, 1'b0,1'b1,1'b0,1'b1,1'b0,32'h00001234);
    vecs[18] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,32'h00001234);
    vecs[19] = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[20] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);

    #2;
    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst; valid = vecs[i].valid; ack_manual = vecs[i].ack;
      data = vecs[i].data; clr = vecs[i].clr;
      tick();
      $display("[TB] vec %0d rdy=%b req=%b done=%b busy=%b to=%b xdata=%h",
               i, ready, req, done, busy, tmo, xdata);
      chk($sformatf("v%0d ready", i), {31'b0, ready}, {31'b0, vecs[i].e_ready});
      chk($sformatf("v%0d req", i),   {31'b0, req},   {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d done", i),  {31'b0, done},  {31'b0, vecs[i].e_done});
      chk($sformatf("v%0d busy", i),  {31'b0, busy},  {31'b0, vecs[i].e_busy});
      chk($sformatf("v%0d tmo", i),   {31'b0, tmo},   {31'b0, vecs[i].e_to});
      chk($sformatf("v%0d xdata", i), xdata, vecs[i].e_xdata);
    end
    rst = 1'b0; valid = 1'b0;

    // Back-to-back: req starts at 0, so the three accepts drive it 1,0,1.
    words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;
    exp_reqs[0] = 1'b1; exp_reqs[1] = 1'b0; exp_reqs[2] = 1'b1;
    rx_auto = 1'b1;
    tick();
    idx = 0; ndone = 0; cur = xdata;
    valid = 1'b1; data = words[0];
    for (cyc = 0; cyc < 100 && ndone < 3; cyc++) begin
      acc = valid && ready;
      prev_req = req;
      tick();
      if (acc) begin
        chk($sformatf("b2b req at accept %0d", idx), {31'b0, req}, {31'b0, exp_reqs[idx]});
        chk($sformatf("b2b data at accept %0d", idx), xdata, words[idx]);
        $display("[TB] b2b accept word=%h req=%b", xdata, req);
        cur = words[idx];
        idx++;
        if (idx < 3) data = words[idx];
        else valid = 1'b0;
      end else begin
        chk("b2b data stable", xdata, cur);
        chk("b2b req stable", {31'b0, req}, {31'b0, prev_req});
      end
      if (done) begin
        ndone++;
        chk("b2b done word", xdata, cur);
      end
    end
    valid = 1'b0;
    chk("b2b done count", ndone, 3);
    chk("b2b accept count", idx, 3);
    tick();
    chk("b2b no extra done", {31'b0, done}, 32'h0);

    // Upstream stall: valid stays high with changing data while waiting.
    valid = 1'b1; data = 32'hA5A5A5A5;
    tick();
    chk("stall accept data", xdata, 32'hA5A5A5A5);
    prev_req = req;
    ndone = 0;
    for (cyc = 0; cyc < 40 && ndone == 0; cyc++) begin
      data = $urandom;
      tick();
      chk("stall data held", xdata, 32'hA5A5A5A5);
      chk("stall req held", {31'b0, req}, {31'b0, prev_req});
      if (done) begin
        ndone = 1;
        valid = 1'b0;
      end
    end
    valid = 1'b0;
    chk("stall done seen", ndone, 1);
    $display("[TB] stall transfer completed after %0d cycles", cyc);
    tick();

    // Timeout: manual ack, never toggled until late.
    ack_manual = ack_model;
    rx_auto = 1'b0;
    tick();
    valid = 1'b1; data = 32'hC0FFEE00;
    tick();
    valid = 1'b0;
    chk("to accept busy", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 15; i++) tick();
    chk("to not yet at 15", {31'b0, tmo}, 32'h0);
    tick();
    chk("to set at 16", {31'b0, tmo}, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    chk("to sticky", {31'b0, tmo}, 32'h1);
    chk("to still waiting", {31'b0, busy}, 32'h1);
    chk("to ready low", {31'b0, ready}, 32'h0);
    $display("[TB] timeout asserted, busy=%b", busy);
    ack_manual = ~ack_manual;
    tick(); tick();
    chk("late ack no early done", {31'b0, done}, 32'h0);
    tick();
    chk("late ack done", {31'b0, done}, 32'h1);
    chk("late ack to kept", {31'b0, tmo}, 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("to cleared", {31'b0, tmo}, 32'h0);

    // Clear on the same edge as a new set: set wins.
    valid = 1'b1; data = 32'h0BADF00D;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to2 not yet", {31'b0, tmo}, 32'h0);
    clr = 1'b1;
    tick();
    chk("set beats clear", {31'b0, tmo}, 32'h1);
    tick();
    clr = 1'b0;
    chk("clear while waiting", {31'b0, tmo}, 32'h0);
    tick(); tick();
    chk("no reset while saturated", {31'b0, tmo}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
